// File: rtl/fifo_reader.sv
// fifo_reader: pulls flits out of an upstream circular FIFO whose read data
// is registered (valid one cycle after the read strobe) and presents them on
// a valid/ready stream through a 2-entry in-order skid buffer.
//
// Ports:
//   clk_i            clock, all state on the rising edge
//   rst_ni           asynchronous active-low reset
//   fifo_empty_i     upstream FIFO empty flag
//   fifo_data_i      upstream registered read data
//   fifo_underflow_i upstream underflow flag (sets err_o)
//   fifo_rd_en_o     read strobe to the upstream FIFO
//   valid_o/data_o   downstream flit, data_o is the oldest buffered flit
//   ready_i          downstream accepts the flit
//   occ_o            skid buffer occupancy, 0..2
//   flit_cnt_o       saturating count of delivered flits
//   err_o            sticky protocol error
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_underflow_i,
  output logic              fifo_rd_en_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  flit_cnt_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [DATA_W-1:0] w_head_next;
  logic [DATA_W-1:0] w_tail_next;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              w_pop;
  logic              w_capture;
  logic              w_overflow;
  logic [1:0]        w_occ;
  logic [2:0]        w_demand;

  assign w_occ      = r_state;
  assign occ_o      = w_occ;
  assign valid_o    = (r_state != EMPTY);
  assign data_o     = r_head;
  assign flit_cnt_o = r_cnt;
  assign err_o      = r_err;
  assign w_pop      = valid_o && ready_i;
  // The flit requested last cycle lands on this edge.
  assign w_capture  = r_inflight;

  // Slots that will still be claimed after this edge: buffered + landing
  // - leaving. A new read is safe only if at most one is claimed, which
  // keeps the buffer at two entries while allowing one flit per cycle.
  assign w_demand     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en_o = rst_ni && !fifo_empty_i && (w_demand <= 3'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= EMPTY;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_inflight <= fifo_rd_en_o;
      if (w_pop && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (fifo_underflow_i || w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    w_overflow   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_capture) begin
          w_head_next  = fifo_data_i;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_pop && w_capture) begin
          // Head leaves and the arriving flit replaces it directly.
          w_head_next = fifo_data_i;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end else if (w_capture) begin
          w_tail_next  = fifo_data_i;
          w_state_next = TWO;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_head_next = r_tail;
          if (w_capture) begin
            w_tail_next = fifo_data_i;
          end else begin
            w_state_next = ONE;
          end
        end else if (w_capture) begin
          // No room: flag it and drop the arriving flit.
          w_overflow = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

endmodule
